// File: rtl/pcm_playback_fifo.sv
// Bus-writable PCM playback FIFO: byte-staged 24-bit samples are queued in block RAM
// and popped to the codec DAC inputs on each rising edge of the audio driver's advance strobe.
module pcm_playback_fifo #(
    parameter int DEPTH        = 512,
    parameter int SAMPLE_WIDTH = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    chipselect,
    input  logic                    write,
    input  logic [15:0]             address,
    input  logic [7:0]              writedata,
    output logic [7:0]              readdata,
    input  logic                    advance,
    output logic [SAMPLE_WIDTH-1:0] dac_left,
    output logic [SAMPLE_WIDTH-1:0] dac_right,
    output logic                    underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [SAMPLE_WIDTH-1:0] mem [DEPTH];

    logic [15:0]             addr_q,     addr_d;
    logic [7:0]              rdata_q,    rdata_d;
    logic                    adv_q;
    logic [2:0][7:0]         stage_q,    stage_d;
    logic                    en_q,       en_d;
    logic                    ovf_q,      ovf_d;
    logic [31:0]             ucnt_q,     ucnt_d;
    logic [31:0]             snap_q,     snap_d;
    logic [AW:0]             fill_q,     fill_d;
    logic [AW-1:0]           wptr_q,     wptr_d;
    logic [AW-1:0]           rptr_q,     rptr_d;
    logic [SAMPLE_WIDTH-1:0] dac_q,      dac_d;
    logic                    uf_q,       uf_d;
    logic [SAMPLE_WIDTH-1:0] ram_rd_q;
    logic                    byp_q,      byp_d;
    logic [SAMPLE_WIDTH-1:0] byp_data_q;

    logic                    wr_en, flush, push_req, pop_req, empty, full, pop_ok, push_ok;
    logic [SAMPLE_WIDTH-1:0] head, push_data;
    logic [15:0]             fill16;

    always_comb begin
        wr_en     = chipselect & write;
        flush     = wr_en && (address == 16'd4) && writedata[1];
        push_req  = wr_en && (address == 16'd3) && !flush;
        pop_req   = advance & ~adv_q;
        empty     = (fill_q == '0);
        full      = (fill_q == FULL_LVL);
        pop_ok    = pop_req & en_q & ~empty;
        push_ok   = push_req & (~full | pop_ok);
        push_data = {stage_q[2], stage_q[1], stage_q[0]};
        head      = byp_q ? byp_data_q : ram_rd_q;
        fill16    = 16'(fill_q);
    end

    always_comb begin
        addr_d  = address;
        stage_d = stage_q;
        en_d    = en_q;
        ovf_d   = ovf_q;
        ucnt_d  = ucnt_q;
        snap_d  = snap_q;
        fill_d  = fill_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        dac_d   = dac_q;
        uf_d    = 1'b0;
        byp_d   = 1'b0;
        rdata_d = 8'h00;

        if (wr_en) begin
            for (int i = 0; i < 3; i++) begin
                if (address == 16'(i)) stage_d[i] = writedata;
            end
            if (address == 16'd4) en_d = writedata[0];
            if (address == 16'd5) ovf_d = 1'b0;
        end
        if (push_req && full && !pop_ok) ovf_d = 1'b1;

        if (pop_req) begin
            dac_d = pop_ok ? head : '0;
            if (en_q && empty) begin
                uf_d = 1'b1;
                if (ucnt_q != 32'hFFFF_FFFF) ucnt_d = ucnt_q + 32'd1;
            end
        end

        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop_ok)  rptr_d = rptr_q + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   fill_d = fill_q + 1'b1;
            2'b01:   fill_d = fill_q - 1'b1;
            default: fill_d = fill_q;
        endcase

        if (flush) begin
            stage_d = '0;
            fill_d  = '0;
            wptr_d  = '0;
            rptr_d  = '0;
        end

        // A write landing on the slot the RAM is reading this cycle would be missed; forward it.
        byp_d = push_ok && (wptr_q == rptr_d);

        // Byte 12 returns the live count, which is exactly what the snapshot captures now.
        if (addr_q == 16'd12) snap_d = ucnt_q;
        case (addr_q)
            16'd4:   rdata_d = {7'b0, en_q};
            16'd5:   rdata_d = {5'b0, ovf_q, full, empty};
            16'd8:   rdata_d = fill16[7:0];
            16'd9:   rdata_d = fill16[15:8];
            16'd12:  rdata_d = ucnt_q[7:0];
            16'd13:  rdata_d = snap_q[15:8];
            16'd14:  rdata_d = snap_q[23:16];
            16'd15:  rdata_d = snap_q[31:24];
            default: rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q     <= '0;
            rdata_q    <= '0;
            adv_q      <= 1'b0;
            stage_q    <= '0;
            en_q       <= 1'b0;
            ovf_q      <= 1'b0;
            ucnt_q     <= '0;
            snap_q     <= '0;
            fill_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            dac_q      <= '0;
            uf_q       <= 1'b0;
            byp_q      <= 1'b0;
            byp_data_q <= '0;
        end else begin
            addr_q     <= addr_d;
            rdata_q    <= rdata_d;
            adv_q      <= advance;
            stage_q    <= stage_d;
            en_q       <= en_d;
            ovf_q      <= ovf_d;
            ucnt_q     <= ucnt_d;
            snap_q     <= snap_d;
            fill_q     <= fill_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            dac_q      <= dac_d;
            uf_q       <= uf_d;
            byp_q      <= byp_d;
            byp_data_q <= push_data;
        end
    end

    // Simple dual-port RAM; read address runs one pointer ahead so the head is ready at pop time.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr_q] <= push_data;
        ram_rd_q <= mem[rptr_d];
    end

    assign readdata  = rdata_q;
    assign dac_left  = dac_q;
    assign dac_right = dac_q;
    assign underflow = uf_q;

endmodule

// File: tb/tb_pcm_playback_fifo.sv
// Directed bench for pcm_playback_fifo with a queue-based reference model checked every cycle.
module tb_pcm_playback_fifo;

    localparam int DEPTH = 16;

    logic        clk, reset, chipselect, write, advance;
    logic [15:0] address;
    logic [7:0]  writedata, readdata;
    logic [23:0] dac_left, dac_right;
    logic        underflow;

    int tests = 0;
    int fails = 0;

    pcm_playback_fifo #(.DEPTH(DEPTH), .SAMPLE_WIDTH(24)) dut (
        .clk(clk), .reset(reset), .chipselect(chipselect), .write(write),
        .address(address), .writedata(writedata), .readdata(readdata),
        .advance(advance), .dac_left(dac_left), .dac_right(dac_right),
        .underflow(underflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state
    logic [23:0] mq[$];
    logic        m_en = 0, m_ovf = 0, m_adv_prev = 0, m_uf = 0;
    logic [31:0] m_cnt = 0, m_snap = 0;
    logic [15:0] m_addr_prev = 0;
    logic [23:0] m_dac = 0;
    logic [7:0]  m_stage [3] = '{8'h0, 8'h0, 8'h0};
    logic [7:0]  m_rd = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                mq.delete();
                m_en = 0; m_ovf = 0; m_adv_prev = 0; m_uf = 0;
                m_cnt = 0; m_snap = 0; m_addr_prev = 0; m_dac = 0; m_rd = 0;
                for (int i = 0; i < 3; i++) m_stage[i] = 8'h0;
            end else begin
                logic        pop, wr, fl;
                logic [15:0] fsz;
                fsz = 16'(mq.size());
                case (m_addr_prev)
                    16'd4:   m_rd = {7'b0, m_en};
                    16'd5:   m_rd = {5'b0, m_ovf, mq.size() == DEPTH, mq.size() == 0};
                    16'd8:   m_rd = fsz[7:0];
                    16'd9:   m_rd = fsz[15:8];
                    16'd12:  m_rd = m_cnt[7:0];
                    16'd13:  m_rd = m_snap[15:8];
                    16'd14:  m_rd = m_snap[23:16];
                    16'd15:  m_rd = m_snap[31:24];
                    default: m_rd = 8'h00;
                endcase
                if (m_addr_prev == 16'd12) m_snap = m_cnt;
                m_addr_prev = address;

                pop = advance && !m_adv_prev;
                m_adv_prev = advance;
                wr = chipselect && write;
                fl = wr && address == 16'd4 && writedata[1];
                m_uf = 0;
                if (pop) begin
                    if (!m_en) m_dac = 0;
                    else if (mq.size() == 0) begin
                        m_dac = 0;
                        m_uf = 1;
                        if (m_cnt != 32'hFFFF_FFFF) m_cnt++;
                    end else m_dac = mq.pop_front();
                end
                if (wr && address == 16'd3 && !fl) begin
                    if (mq.size() < DEPTH) mq.push_back({m_stage[2], m_stage[1], m_stage[0]});
                    else m_ovf = 1;
                end
                if (wr && address <= 16'd2) m_stage[address[1:0]] = writedata;
                if (wr && address == 16'd4) m_en = writedata[0];
                if (wr && address == 16'd5) m_ovf = 0;
                if (fl) begin
                    mq.delete();
                    for (int i = 0; i < 3; i++) m_stage[i] = 8'h0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("cyc_dac_left",  dac_left,  m_dac);
            chk("cyc_dac_right", dac_right, m_dac);
            chk("cyc_underflow", underflow, m_uf);
            chk("cyc_readdata",  readdata,  m_rd);
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        chipselect = 1; write = 1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 0; write = 0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string nm);
        @(negedge clk);
        address = a;
        repeat (2) @(negedge clk);
        chk(nm, readdata, exp);
    endtask

    task automatic commit(input logic [23:0] s);
        wr(0, s[7:0]);
        wr(1, s[15:8]);
        wr(2, s[23:16]);
        wr(3, 8'h00);
    endtask

    task automatic pop_one();
        @(negedge clk);
        advance = 1;
        @(negedge clk);
        advance = 0;
    endtask

    function automatic logic [23:0] samp(input int i);
        return {8'(i), 8'(8'hA0 + i), 8'(8'h30 ^ i)};
    endfunction

    initial begin
        reset = 1; chipselect = 0; write = 0; address = 0; writedata = 0; advance = 0;
        repeat (3) @(negedge clk);
        reset = 0;
        chk("rst_dac", dac_left, 0);
        chk("rst_readdata", readdata, 0);
        chk("rst_underflow", underflow, 0);
        rd(5, 8'h01, "rst_status");

        // single sample, held advance
        wr(0, 8'h56); wr(1, 8'h34); wr(2, 8'h12); wr(3, 8'h00); wr(4, 8'h01);
        @(negedge clk);
        advance = 1;
        @(negedge clk);
        chk("t1_dac_left", dac_left, 24'h123456);
        chk("t1_dac_right", dac_right, 24'h123456);
        repeat (2) @(negedge clk);
        advance = 0;
        chk("t1_dac_hold", dac_left, 24'h123456);
        rd(8, 8'h00, "t1_fill");

        // underflows on empty FIFO
        repeat (3) begin
            pop_one();
            chk("t2_uf_pulse", underflow, 1);
            chk("t2_dac_zero", dac_left, 0);
        end
        rd(12, 8'h03, "t2_cnt0");
        rd(13, 8'h00, "t2_cnt1");
        rd(14, 8'h00, "t2_cnt2");
        rd(15, 8'h00, "t2_cnt3");

        // overfill with playback disabled
        wr(4, 8'h00);
        for (int i = 0; i < DEPTH + 2; i++) commit(samp(i));
        rd(8, 8'(DEPTH), "t3_fill_lo");
        rd(9, 8'h00, "t3_fill_hi");
        rd(5, 8'h06, "t3_status_ovf");
        wr(5, 8'h00);
        rd(5, 8'h02, "t3_status_clr");
        wr(4, 8'h01);
        for (int i = 0; i < DEPTH; i++) begin
            pop_one();
            chk("t3_order", dac_left, samp(i));
        end
        rd(5, 8'h01, "t3_empty");

        // full FIFO, commit coincident with a pop
        for (int i = 0; i < DEPTH; i++) commit(samp(i + 8'h40));
        wr(0, 8'hEE); wr(1, 8'hFF); wr(2, 8'hC0);
        @(negedge clk);
        chipselect = 1; write = 1; address = 3; advance = 1;
        @(negedge clk);
        chipselect = 0; write = 0; advance = 0;
        chk("t4_first_pop", dac_left, samp(8'h40));
        rd(8, 8'(DEPTH), "t4_fill");
        rd(5, 8'h02, "t4_status");
        for (int i = 0; i < DEPTH; i++) pop_one();
        chk("t4_last", dac_left, 24'hC0FFEE);
        rd(5, 8'h01, "t4_empty");

        // flush with enable
        for (int i = 0; i < 10; i++) commit(samp(i + 8'h80));
        wr(4, 8'h03);
        rd(8, 8'h00, "t5_fill");
        rd(5, 8'h01, "t5_status");
        rd(4, 8'h01, "t5_enable");
        pop_one();
        chk("t5_uf", underflow, 1);
        chk("t5_dac", dac_left, 0);
        rd(12, 8'h04, "t5_cnt");
        wr(3, 8'h00);
        pop_one();
        chk("t5_stage_clr", dac_left, 0);
        chk("t5_no_uf", underflow, 0);

        // asynchronous reset mid-stream
        commit(24'h00ABCD);
        pop_one();
        chk("t6_dac", dac_left, 24'h00ABCD);
        for (int i = 0; i < 5; i++) commit(samp(i + 8'hC0));
        @(negedge clk);
        #2 reset = 1;
        #1;
        chk("t6_rst_dacl", dac_left, 0);
        chk("t6_rst_dacr", dac_right, 0);
        chk("t6_rst_uf", underflow, 0);
        repeat (2) @(negedge clk);
        reset = 0;
        rd(8, 8'h00, "t6_fill");
        rd(5, 8'h01, "t6_status");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pcm_playback_fifo.md
Name: pcm_playback_fifo

Overview:
- Bus-writable playback path: the other direction of the SFFT capture path.
- Software writes 24-bit PCM samples byte-by-byte over the 8-bit chipselect/write/address bus into an on-chip FIFO.
- On each codec advance edge the block pops one sample and presents it to the audio driver's dac_left/dac_right inputs.
- Status, fill level and underflow/overflow telemetry are readable over the same bus.

Parameters:
- DEPTH, 512, FIFO depth in samples; power of two, 16..4096.
- SAMPLE_WIDTH, 24, PCM sample width; fixed at 24 for this revision.

Ports:
- clk  input  1  system clock (50 MHz domain of the audio driver).
- reset  input  1  asynchronous, active-high reset.
- chipselect  input  1  bus select.
- write  input  1  bus write strobe; qualified by chipselect.
- address  input  16  byte address.
- writedata  input  8  bus write data.
- readdata  output  8  bus read data.
- advance  input  1  audio driver sample strobe, synchronous to clk; may be high for multiple cycles.
- dac_left  output  24  sample to codec left channel.
- dac_right  output  24  sample to codec right channel.
- underflow  output  1  one-cycle pulse when a pop is attempted on an empty FIFO while enabled.

Behaviour:
- Reset values: dac_left = dac_right = 0, readdata = 0, underflow = 0. FIFO empty, staging bytes 0, enable = 0, overflow sticky = 0, underflow count = 0.
- Address map (byte addresses; multi-byte fields little-endian, byte 0 = bits 7:0, matching software endianness):
  - 0-2: write-only staging bytes, sample bits 7:0, 15:8, 23:16.
  - 3: a write commits {stage2, stage1, stage0} as one sample. writedata is ignored. Staging bytes are retained.
  - 4: control. Write: bit0 = enable, bit1 = flush (self-clearing). Read: returns bit0 = enable, other bits 0.
  - 5: status read: bit0 empty, bit1 full, bit2 overflow sticky. Any write clears overflow sticky.
  - 8-9: fill level, zero-extended to 16 bits.
  - 12-15: underflow count, 32 bits, saturating at 0xFFFFFFFF.
  - Any other address reads 0x00. Writes to unmapped addresses have no effect.
- Read latency: address is registered every cycle. readdata is a registered function of the previous cycle's address, i.e. valid 2 cycles after address is applied. Reads have no side effects except the snapshot below.
- Counter snapshot: when the registered address equals 12, the full 32-bit count is copied into a snapshot register. Reads of 12-15 return snapshot bytes, giving tear-free reads when byte 12 is read first.
- Advance detection: advance is registered once; pop_req = advance & ~advance_q (rising edge). A level held high yields exactly one pop.
- On pop_req:
  - enable = 1 and FIFO non-empty: pop head; dac_left = dac_right = popped sample on the next cycle (1-cycle latency from pop_req).
  - enable = 1 and FIFO empty: dac outputs go to 0, underflow pulses 1 cycle, underflow count increments (saturating).
  - enable = 0: no pop, dac outputs go to 0, no underflow.
- Between pops, dac outputs hold their last value.
- Push on commit: if not full, sample is written at the tail. If full, the sample is dropped and overflow sticky is set.
- Simultaneous push and pop:
  - Both are evaluated against pre-cycle state.
  - Empty FIFO: pop underflows, push is accepted, fill ends at 1.
  - Full FIFO: push is accepted alongside the pop, fill stays at DEPTH.
- Flush: resets read/write pointers and fill to 0 and clears staging bytes. Does not change enable, overflow sticky, underflow count or dac outputs. A commit in the same cycle as flush is discarded. A pop in the same cycle as flush sees the pre-flush state.
- Fill level: range 0..DEPTH. full = (fill == DEPTH). Pointers wrap modulo DEPTH.
- Storage: inferred simple dual-port RAM, synchronous read. The head-word prefetch must keep the 1-cycle pop-to-output latency.
- Asynchronous reset mid-stream: all state returns to reset values immediately. FIFO contents are discarded (RAM contents are don't-care).

Test Plan:
- Reset, then write bytes 0x56, 0x34, 0x12 to addresses 0-2, write address 3, write 0x01 to address 4, pulse advance for 3 cycles -> exactly one pop; dac_left = dac_right = 0x123456 one cycle after the edge; fill (addr 8) reads 0.
- Enable with empty FIFO, 3 advance edges -> 3 underflow pulses, dac = 0; read addresses 12, 13, 14, 15 -> 0x03, 0x00, 0x00, 0x00.
- Commit DEPTH+2 samples with enable = 0 -> fill = DEPTH, status reads 0x06 (full and overflow); write to address 5 -> status reads 0x02; pops then return the first DEPTH samples in order.
- Full FIFO, commit in the same cycle as an advance edge -> fill stays DEPTH, no overflow; the last sample is retrieved after DEPTH pops.
- 10 samples queued, write 0x03 to address 4 (enable plus flush) -> fill = 0, status empty; next advance edge gives an underflow; underflow count is retained across the flush.
- Assert reset asynchronously between clock edges with 5 samples queued and dac = 0x00ABCD -> dac = 0 and underflow = 0 immediately; after release, fill = 0 and status reads 0x01.
